// File: rtl/se_stream_out.sv
// Streams a sorted array out one element per accepted handshake.
// Define SE_STREAM_ASCEND_EN to emit the array from the top element down.
module se_stream_out #(
  parameter int ARRAYLENGTH = 10,
  parameter int DATAWIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATAWIDTH*ARRAYLENGTH-1:0] array_in,
  input  logic                           valid_in,
  output logic [DATAWIDTH-1:0]           elem_out,
  output logic                           elem_valid,
  input  logic                           elem_ready,
  output logic                           elem_last,
  output logic                           busy,
  output logic                           overflow
);

  localparam int         ArrW    = DATAWIDTH * ARRAYLENGTH;
  localparam logic [7:0] LastIdx = 8'(ARRAYLENGTH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_q, state_d;
  logic [ArrW-1:0]      hold_q, hold_d;
  logic [7:0]           index_q, index_d;
  logic [DATAWIDTH-1:0] elem_q, elem_d;
  logic                 ovf_q, ovf_d;
  logic                 xfer, at_last;

  // Maps a stream position to its array element; constant-index mux keeps
  // the select width-clean for any ARRAYLENGTH.
  function automatic logic [DATAWIDTH-1:0] pick(input logic [ArrW-1:0] arr,
                                                input logic [7:0] pos);
    logic [DATAWIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < ARRAYLENGTH; k++) begin
`ifdef SE_STREAM_ASCEND_EN
      if (pos == 8'(ARRAYLENGTH - 1 - k)) r = arr[k*DATAWIDTH +: DATAWIDTH];
`else
      if (pos == 8'(k)) r = arr[k*DATAWIDTH +: DATAWIDTH];
`endif
    end
    return r;
  endfunction

  assign xfer    = (state_q == STREAM) && elem_ready;
  assign at_last = (index_q == LastIdx);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and infers a latch.
    state_d    = state_q;
    hold_d     = hold_q;
    index_d    = index_q;
    elem_d     = elem_q;
    ovf_d      = 1'b0;
    elem_valid = (state_q == STREAM);
    busy       = (state_q == STREAM);
    elem_last  = (state_q == STREAM) && at_last;
    elem_out   = elem_q;
    overflow   = ovf_q;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_d = STREAM;
          hold_d  = array_in;
          index_d = 8'd0;
          elem_d  = pick(array_in, 8'd0);
        end
      end
      STREAM: begin
        if (xfer && at_last) begin
          // A new array may take over the freed slot on the same edge.
          if (valid_in) begin
            hold_d  = array_in;
            index_d = 8'd0;
            elem_d  = pick(array_in, 8'd0);
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            index_d = index_q + 8'd1;
            elem_d  = pick(hold_q, index_q + 8'd1);
          end
          ovf_d = valid_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the holding register is reset because it is observable
  // state with a defined reset value, not scratch storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      index_q <= 8'd0;
      elem_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      index_q <= index_d;
      elem_q  <= elem_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/se_stream_out.md
SE_STREAM_OUT -- requirements
Module: se_stream_out

Interface
REQ-001: ARRAYLENGTH, default 10, is the number of elements per array, legal range 3..255.
REQ-002: DATAWIDTH, default 8, is the bits per element, legal range 2..255.
REQ-003: clk  input  1  is the single clock; all state changes on the rising edge.
REQ-004: rst  input  1  is the synchronous active-high reset, sampled on the rising edge of clk.
REQ-005: array_in  input  DATAWIDTH*ARRAYLENGTH  is the sorted array from the sort engine; element k occupies bits [DATAWIDTH*(k+1)-1 : DATAWIDTH*k].
REQ-006: valid_in  input  1  is a one-cycle qualifier for array_in; there is no backpressure toward the sort engine.
REQ-007: elem_out  output  DATAWIDTH  is the current streamed element, registered.
REQ-008: elem_valid  output  1  is high while elem_out holds an unconsumed element.
REQ-009: elem_ready  input  1  is the downstream accept; a transfer occurs on any edge where elem_valid=1 and elem_ready=1.
REQ-010: elem_last  output  1  is high with the final element of each array.
REQ-011: busy  output  1  is high in STREAM state.
REQ-012: overflow  output  1  is a one-cycle pulse when an input array is dropped.

Function
REQ-013: The FSM SHALL have two states: IDLE (elem_valid=0) and STREAM (elem_valid=1).
REQ-014: In IDLE with valid_in=1: on that edge, capture array_in into the holding register, set index=0, load elem_out with element 0, and go to STREAM; elem_valid rises the following cycle (1-cycle latency).
REQ-015: In STREAM, on each transfer: index increments and elem_out loads the next element; no bubble cycles between elements while elem_ready=1.
REQ-016: Without a transfer, elem_out, elem_last and index SHALL hold their values (AXI-style stability).
REQ-017: elem_last=1 exactly when index=ARRAYLENGTH-1.
REQ-018: On a transfer with elem_last=1 and valid_in=0: go to IDLE with elem_valid=0 and elem_last=0 on the next cycle.
REQ-019: On a transfer with elem_last=1 and valid_in=1 (simultaneous event): capture the new array and present its element 0 on the next cycle; the FSM stays in STREAM with no idle cycle.
REQ-020: valid_in=1 in STREAM without the freeing transfer of REQ-019: drop the array, assert overflow for one cycle, and leave the current stream unaffected.
REQ-021: Index counter width is 8 bits; it never exceeds ARRAYLENGTH-1 and resets to 0 on every capture.
REQ-022: array_in is not required to be stable after the valid_in cycle.

Reset
REQ-023: While rst=1, the FSM SHALL go to IDLE and index=0; elem_valid, elem_last, busy and overflow =0; elem_out=0; holding register=0.
REQ-024: Reset in mid-stream discards the remaining elements, and valid_in in the reset cycle is ignored.
REQ-025: Reset has priority over every other event.

Configuration
REQ-026: Macro SE_STREAM_ASCEND_EN, when defined: emit element ARRAYLENGTH-1 first, down to element 0 (ascending values from the sort engine), with elem_last on element 0.
REQ-027: Without SE_STREAM_ASCEND_EN: emit element 0 first, up to ARRAYLENGTH-1 (descending values).
REQ-028: All handshake, latency and overflow behaviour is identical in both builds.

Verification (ARRAYLENGTH=4, DATAWIDTH=8, macro undefined unless stated)
REQ-029: array_in={8'h01,8'h05,8'h09,8'h0F} (element0=0x0F), valid_in at cycle 0, elem_ready=1 -> elem_out 0F,09,05,01 in cycles 1-4, elem_last only in cycle 4, elem_valid=0 in cycle 5.
REQ-030: Same array, elem_ready low in cycles 2-3 -> 09 held stable in cycles 2-4, sequence completes in cycle 6, no duplicates or loss.
REQ-031: Second array {8'h00,8'h10,8'h20,8'h30} valid_in in the cycle 01 is accepted with last=1 -> cycle 5 shows 30 with no gap and overflow=0.
REQ-032: valid_in in cycle 2 mid-stream -> overflow=1 in cycle 3 only, first stream unchanged, FSM returns to IDLE after 01.
REQ-033: rst=1 in cycle 2 mid-stream -> cycle 3 shows elem_valid=0 and busy=0; the next valid_in restarts cleanly from element 0.
REQ-034: SE_STREAM_ASCEND_EN defined with the REQ-029 stimulus -> elem_out 01,05,09,0F, with elem_last on 0F.
